// File: rtl/spectrum_frame_ctrl.sv
// Spectrum frame controller: turns 8 FFT band magnitudes into LED column bitmaps
// with per-band peak-hold markers that decay at most one row per frame.
module spectrum_frame_ctrl #(
  parameter int unsigned CLK_FRE  = 50_000_000,
  parameter int unsigned DECAY_MS = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fft_valid,
  input  logic [63:0] fft_mag,
  input  logic        disp_ready,
  output logic        disp_start,
  output logic [63:0] disp_data,
  output logic        busy,
  output logic [7:0]  drop_cnt
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PROC  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  localparam int unsigned TICKS = CLK_FRE / 1000 * DECAY_MS;

  logic [1:0]       state_q, state_d;
  logic [63:0]      cap_q, cap_d;
  logic [63:0]      shadow_q, shadow_d;
  logic [63:0]      disp_data_q, disp_data_d;
  logic             disp_start_q, disp_start_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [2:0]       band_q, band_d;
  logic [7:0][3:0]  peak_q, peak_d;
  logic             flag_q, flag_d;
  logic             decay_this_q, decay_this_d;
  logic [31:0]      timer_q, timer_d;

  logic       tick;
  logic [7:0] mag;
  logic [8:0] sum;
  logic [3:0] h, p, p_new;
  logic [8:0] h_mask;
  logic [7:0] col;

  always_comb begin
    state_d      = state_q;
    cap_d        = cap_q;
    shadow_d     = shadow_q;
    disp_data_d  = disp_data_q;
    disp_start_d = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    band_d       = band_q;
    peak_d       = peak_q;
    decay_this_d = decay_this_q;

    // Decay timer; a zero period disables it entirely.
    tick    = (TICKS != 0) && (timer_q == TICKS - 1);
    timer_d = tick ? 32'd0 : ((TICKS != 0) ? timer_q + 32'd1 : 32'd0);
    flag_d  = flag_q;

    // Per-band height and peak for the band currently selected.
    mag    = cap_q[{band_q, 3'b000} +: 8];
    sum    = {1'b0, mag} + 9'd31;
    h      = sum[8:5];
    p      = peak_q[band_q];
    if (h >= p)           p_new = h;
    else if (decay_this_q) p_new = p - 4'd1;
    else                  p_new = p;
    h_mask = (9'd1 << h) - 9'd1;
    col    = h_mask[7:0];
    if (p_new != 4'd0) col = col | (8'd1 << (p_new - 4'd1));

    if (fft_valid && state_q != IDLE && drop_cnt_q != 8'd255)
      drop_cnt_d = drop_cnt_q + 8'd1;

    case (state_q)
      IDLE: if (fft_valid) begin
        cap_d        = fft_mag;
        decay_this_d = flag_q;
        flag_d       = 1'b0;
        band_d       = 3'd0;
        state_d      = PROC;
      end
      PROC: begin
        shadow_d[{band_q, 3'b000} +: 8] = col;
        peak_d[band_q] = p_new;
        band_d = band_q + 3'd1;
        if (band_q == 3'd7) state_d = ISSUE;
      end
      ISSUE: if (disp_ready) begin
        disp_data_d  = shadow_q;
        disp_start_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A tick on the capture edge belongs to the next frame, so it wins over the clear.
    if (tick) flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cap_q        <= '0;
      shadow_q     <= '0;
      disp_data_q  <= '0;
      disp_start_q <= 1'b0;
      drop_cnt_q   <= '0;
      band_q       <= '0;
      peak_q       <= '0;
      flag_q       <= 1'b0;
      decay_this_q <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      cap_q        <= cap_d;
      shadow_q     <= shadow_d;
      disp_data_q  <= disp_data_d;
      disp_start_q <= disp_start_d;
      drop_cnt_q   <= drop_cnt_d;
      band_q       <= band_d;
      peak_q       <= peak_d;
      flag_q       <= flag_d;
      decay_this_q <= decay_this_d;
      timer_q      <= timer_d;
    end
  end

  assign disp_start = disp_start_q;
  assign disp_data  = disp_data_q;
  assign busy       = (state_q != IDLE);
  assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_spectrum_frame_ctrl.sv
// Directed bench for spectrum_frame_ctrl: table of single-frame vectors plus
// hand-written sequences for peak hold/decay, drops, saturation and mid-frame reset.
module tb_spectrum_frame_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fft_valid = 1'b0;
  logic [63:0] fft_mag = '0;
  logic        disp_ready = 1'b1;
  logic        disp_start;
  logic [63:0] disp_data;
  logic        busy;
  logic [7:0]  drop_cnt;

  // Decay period shortened to 200 cycles.
  spectrum_frame_ctrl #(.CLK_FRE(200_000), .DECAY_MS(1)) dut (
    .clk(clk), .rst_n(rst_n), .fft_valid(fft_valid), .fft_mag(fft_mag),
    .disp_ready(disp_ready), .disp_start(disp_start), .disp_data(disp_data),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int starts = 0;

  always @(posedge clk) if (disp_start) starts++;

  typedef struct {
    logic [63:0] mag;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    fft_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [63:0] m);
    @(negedge clk);
    fft_valid = 1'b1;
    fft_mag = m;
    @(posedge clk);
    #1 fft_valid = 1'b0;
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    while (!disp_start && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic frame(input string name, input logic [63:0] m, input logic [63:0] exp);
    int lat;
    send(m);
    wait_start(lat);
    chk({name, "_lat"}, 64'(lat), 64'd9);
    chk({name, "_data"}, disp_data, exp);
    @(posedge clk);
    #1 chk({name, "_pulse1"}, 64'(disp_start), 64'd0);
  endtask

  initial begin
    int lat, s0;
    vecs[0] = '{mag: 64'h0, exp: 64'h0};
    vecs[1] = '{mag: 64'h0000_0000_0021_20FF, exp: 64'h0000_0000_0003_01FF};
    vecs[2] = '{mag: 64'hFF_E1_E0_80_21_20_01_00, exp: 64'hFF_FF_7F_0F_03_01_01_00};
    vecs[3] = '{mag: 64'h0101_0101_0101_0101, exp: 64'h0101_0101_0101_0101};

    // Reset state while held low.
    #12;
    chk("rst_start", 64'(disp_start), 64'd0);
    chk("rst_data", disp_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);

    for (int i = 0; i < 4; i++) begin
      do_reset();
      frame($sformatf("vec%0d", i), vecs[i].mag, vecs[i].exp);
      chk($sformatf("vec%0d_drop", i), 64'(drop_cnt), 64'd0);
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
    end

    // Peak held without a decay tick.
    do_reset();
    frame("hold_a", 64'hFF, 64'hFF);
    frame("hold_b", 64'h40, 64'h83);

    // One tick between frames: one decrement; flag consumed so next frame holds.
    do_reset();
    frame("dec1_a", 64'hFF, 64'hFF);
    repeat (250) @(posedge clk);
    frame("dec1_b", 64'h40, 64'h43);
    frame("dec1_c", 64'h40, 64'h43);

    // Two ticks still collapse to one decrement.
    do_reset();
    frame("dec2_a", 64'hFF, 64'hFF);
    repeat (450) @(posedge clk);
    frame("dec2_b", 64'h40, 64'h43);

    // Display stalled: second valid dropped, first frame delivered.
    do_reset();
    disp_ready = 1'b0;
    send(64'hFF);
    repeat (20) @(posedge clk);
    send(64'h40);
    chk("stall_drop", 64'(drop_cnt), 64'd1);
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_hold", disp_data, 64'd0);
    chk("stall_nostart", 64'(starts), 64'(starts));
    s0 = starts;
    @(negedge clk);
    disp_ready = 1'b1;
    wait_start(lat);
    chk("stall_lat_ok", 64'(lat < 40), 64'd1);
    chk("stall_data", disp_data, 64'hFF);
    repeat (15) @(posedge clk);
    #1 chk("stall_once", 64'(starts - s0), 64'd1);
    chk("stall_idle", 64'(busy), 64'd0);

    // Drop counter saturation.
    disp_ready = 1'b0;
    send(64'h0);
    @(negedge clk);
    fft_valid = 1'b1;
    repeat (260) @(posedge clk);
    #1 fft_valid = 1'b0;
    chk("drop_sat", 64'(drop_cnt), 64'd255);
    disp_ready = 1'b1;
    repeat (5) @(posedge clk);

    // Reset during PROC abandons the frame.
    do_reset();
    frame("pre_rst", 64'hFF, 64'hFF);
    send(64'hFF);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_start", 64'(disp_start), 64'd0);
    chk("mid_rst_data", disp_data, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    s0 = starts;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1 chk("mid_rst_nostart", 64'(starts - s0), 64'd0);
    frame("post_rst", 64'h40, 64'h03);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
